// File: rtl/spi_mitm_channel_if.sv
// spi_mitm_channel_if: intercepted SPI bus, synchronised inputs and driven outputs
interface spi_mitm_channel_if;
  logic ss_in, sclk_in, mosi_in, miso_in;
  logic ss_out, sclk_out, mosi_out, miso_out;
  modport slave (input ss_in, sclk_in, mosi_in, miso_in, output ss_out, sclk_out, mosi_out, miso_out);
  modport master (output ss_in, sclk_in, mosi_in, miso_in, input ss_out, sclk_out, mosi_out, miso_out);
endinterface

// File: rtl/spi_mitm_channel.sv
// spi_mitm_channel: 1-cycle SPI pass-through with frame capture, read-data substitution and blocking
module spi_mitm_channel #(
  parameter int CMD_BITS = 3,
  parameter int ADDR_BITS = 9,
  parameter int DATA_BITS = 8,
  parameter logic [CMD_BITS-1:0] READ_CMD = 3'b110,
  parameter int MODE_WIDTH = 2,
  parameter int COUNT_WIDTH = 16,
  localparam int FRAME_BITS = CMD_BITS + ADDR_BITS + DATA_BITS
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic [MODE_WIDTH-1:0] mode,
  input  logic [ADDR_BITS-1:0] sub_addr,
  input  logic [DATA_BITS-1:0] sub_data,
  spi_mitm_channel_if.slave bus,
  output logic comm_active,
  output logic frame_valid,
  output logic frame_error,
  output logic [FRAME_BITS-1:0] frame_mosi,
  output logic [FRAME_BITS-1:0] frame_miso,
  output logic [COUNT_WIDTH-1:0] frame_count
);
  localparam int HDR = CMD_BITS + ADDR_BITS;
  localparam int CW = $clog2(FRAME_BITS + 2);
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;
  state_t state, state_nx;
  logic ss_d, sclk_d, ss_rise, ss_fall, sclk_rise, start, fin, frame_ok, sub, blk, data_bit;
  logic [CW-1:0] bit_cnt, cnt_nx, sh;
  logic [FRAME_BITS-1:0] mosi_sr, miso_sr, mosi_nx, miso_nx;
  logic [HDR-1:0] hdr;
  logic [MODE_WIDTH-1:0] mode_l, mode_e;
  logic [ADDR_BITS-1:0] addr_l;
  logic [DATA_BITS-1:0] data_l;
  // state register; reset parks in WAIT_IDLE so a frame cut by reset is dropped
  always_ff @(posedge sys_clk) state <= rst ? WAIT_IDLE : state_nx;
  // next-state: wait for SS low, start on SS rise, finish on SS fall
  always_comb state_nx = state == WAIT_IDLE ? (bus.ss_in ? WAIT_IDLE : IDLE) :
                         state == IDLE ? (ss_rise ? ACTIVE : IDLE) :
                         state == ACTIVE ? (ss_fall ? IDLE : ACTIVE) : WAIT_IDLE;
  // FSM output decode
  always_comb begin
    comm_active = state == ACTIVE;
    start = state == IDLE && ss_rise;
    fin = comm_active && ss_fall;
  end
  // edge detection, shift/count look-ahead and substitution decision
  always_comb begin
    ss_rise = bus.ss_in & ~ss_d;
    ss_fall = ~bus.ss_in & ss_d;
    sclk_rise = bus.sclk_in & ~sclk_d;
    mosi_nx = sclk_rise ? {mosi_sr[FRAME_BITS-2:0], bus.mosi_in} : mosi_sr;
    miso_nx = sclk_rise ? {miso_sr[FRAME_BITS-2:0], bus.miso_in} : miso_sr;
    cnt_nx = sclk_rise && bit_cnt != CW'(FRAME_BITS + 1) ? bit_cnt + 1'b1 : bit_cnt;
    frame_ok = cnt_nx == CW'(FRAME_BITS);
    sh = bit_cnt - CW'(HDR);
    hdr = HDR'(mosi_sr >> sh);
    data_bit = 1'(data_l >> (CW'(DATA_BITS - 1) - sh));
    mode_e = comm_active ? mode_l : mode;
    blk = mode_e == MODE_WIDTH'(3);
    sub = comm_active && !ss_fall && hdr[HDR-1 -: CMD_BITS] == READ_CMD &&
          bit_cnt >= CW'(HDR) && bit_cnt < CW'(FRAME_BITS) &&
          (mode_l == MODE_WIDTH'(1) || (mode_l == MODE_WIDTH'(2) && hdr[ADDR_BITS-1:0] == addr_l));
  end
  // registered bus outputs, frame capture and counters
  always_ff @(posedge sys_clk)
    if (rst) begin
      ss_d <= 1'b0;
      sclk_d <= 1'b0;
      bus.ss_out <= 1'b0;
      bus.sclk_out <= 1'b0;
      bus.mosi_out <= 1'b0;
      bus.miso_out <= 1'b0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      mode_l <= '0;
      addr_l <= '0;
      data_l <= '0;
      bit_cnt <= '0;
      mosi_sr <= '0;
      miso_sr <= '0;
      frame_mosi <= '0;
      frame_miso <= '0;
      frame_count <= '0;
    end else begin
      ss_d <= bus.ss_in;
      sclk_d <= bus.sclk_in;
      bus.ss_out <= !blk && bus.ss_in;
      bus.sclk_out <= !blk && bus.sclk_in;
      bus.mosi_out <= !blk && bus.mosi_in;
      bus.miso_out <= !blk && (sub ? data_bit : bus.miso_in);
      frame_valid <= fin && frame_ok;
      frame_error <= fin && !frame_ok;
      if (start) begin
        mode_l <= mode;
        addr_l <= sub_addr;
        data_l <= sub_data;
        bit_cnt <= CW'(sclk_rise);
        mosi_sr <= sclk_rise ? FRAME_BITS'(bus.mosi_in) : '0;
        miso_sr <= sclk_rise ? FRAME_BITS'(bus.miso_in) : '0;
      end else if (comm_active) begin
        bit_cnt <= cnt_nx;
        mosi_sr <= mosi_nx;
        miso_sr <= miso_nx;
      end
      if (fin && frame_ok) begin
        frame_mosi <= mosi_nx;
        frame_miso <= miso_nx;
        frame_count <= frame_count + 1'b1;
      end
    end
endmodule

// File: tb/tb_spi_mitm_channel.sv
// tb_spi_mitm_channel: directed checks of pass-through, capture, substitution, errors, reset and blocking
module tb_spi_mitm_channel;
  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [8:0] sub_addr = 9'h0;
  logic [7:0] sub_data = 8'h0;
  logic comm_active, frame_valid, frame_error;
  logic [19:0] frame_mosi, frame_miso;
  logic [15:0] frame_count;
  logic [31:0] mo, so;
  logic fv, fe, tail, act, ca;
  int n_cmp = 0;
  int n_bad = 0;
  spi_mitm_channel_if bus();
  spi_mitm_channel dut (
    .sys_clk(sys_clk), .rst(rst), .mode(mode), .sub_addr(sub_addr), .sub_data(sub_data),
    .bus(bus), .comm_active(comm_active), .frame_valid(frame_valid), .frame_error(frame_error),
    .frame_mosi(frame_mosi), .frame_miso(frame_miso), .frame_count(frame_count)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic sample_act();
    act = act | bus.ss_out | bus.sclk_out | bus.mosi_out | bus.miso_out;
  endtask
  task automatic run_frame(input logic [31:0] mv, input logic [31:0] sv, input int n);
    mo = '0;
    so = '0;
    act = 1'b0;
    ca = 1'b0;
    bus.ss_in = 1'b1;
    tick(2);
    for (int i = 0; i < n; i++) begin
      bus.mosi_in = mv[n-1-i];
      bus.miso_in = sv[n-1-i];
      bus.sclk_in = 1'b0;
      tick(2);
      mo[n-1-i] = bus.mosi_out;
      so[n-1-i] = bus.miso_out;
      if (i == 0) ca = comm_active;
      sample_act();
      bus.sclk_in = 1'b1;
      tick(2);
      sample_act();
    end
    bus.sclk_in = 1'b0;
    tick(2);
    bus.ss_in = 1'b0;
    tick(1);
    fv = frame_valid;
    fe = frame_error;
    sample_act();
    tick(1);
    tail = frame_valid | frame_error;
    tick(2);
    sample_act();
  endtask
  initial begin
    bus.ss_in = 1'b0;
    bus.sclk_in = 1'b0;
    bus.mosi_in = 1'b0;
    bus.miso_in = 1'b0;
    tick(2);
    chk("reset_bus_ctl", {bus.ss_out, bus.sclk_out, bus.mosi_out, bus.miso_out, comm_active, frame_valid, frame_error}, 0);
    chk("reset_frames", {frame_mosi, frame_miso}, 0);
    chk("reset_count", frame_count, 0);
    rst = 1'b0;
    tick(2);
    bus.sclk_in = 1'b1;
    chk("latency_before", bus.sclk_out, 0);
    tick(1);
    chk("latency_after", bus.sclk_out, 1);
    bus.sclk_in = 1'b0;
    tick(2);
    mode = 2'd0;
    run_frame(32'hC4D00, 32'h000A3, 20);
    chk("fwd_active", ca, 1);
    chk("fwd_mosi_out", mo, 32'hC4D00);
    chk("fwd_miso_out", so, 32'h000A3);
    chk("fwd_valid", {fv, fe, tail}, 3'b100);
    chk("fwd_frame_mosi", frame_mosi, 32'hC4D00);
    chk("fwd_frame_miso", frame_miso, 32'h000A3);
    chk("fwd_count", frame_count, 1);
    mode = 2'd1;
    sub_data = 8'h5c;
    sub_addr = 9'h120;
    run_frame(32'hD2000, 32'h000B5, 20);
    mode = 2'd0;
    chk("suball_miso_out", so, 32'h0005C);
    chk("suball_frame_miso", frame_miso, 32'h000B5);
    chk("suball_count", frame_count, 2);
    mode = 2'd1;
    run_frame(32'hA376D, 32'h0F0F3, 20);
    chk("suball_wr_miso_out", so, 32'h0F0F3);
    chk("suball_wr_frame_mosi", frame_mosi, 32'hA376D);
    chk("suball_wr_count", frame_count, 3);
    mode = 2'd2;
    run_frame(32'hC4D00, 32'h000A3, 20);
    chk("submatch_miss_miso_out", so, 32'h000A3);
    chk("submatch_miss_count", frame_count, 4);
    run_frame(32'hD2000, 32'h000B5, 20);
    chk("submatch_hit_miso_out", so, 32'h0005C);
    chk("submatch_hit_frame_miso", frame_miso, 32'h000B5);
    chk("submatch_hit_count", frame_count, 5);
    run_frame(32'h00C4D, 32'h00FFF, 12);
    chk("short_error", {fv, fe, tail}, 3'b010);
    run_frame(32'h1FFFFF, 32'h155555, 21);
    chk("long_error", {fv, fe, tail}, 3'b010);
    chk("errors_count", frame_count, 5);
    chk("errors_frame_mosi", frame_mosi, 32'hD2000);
    chk("errors_frame_miso", frame_miso, 32'h000B5);
    mode = 2'd0;
    bus.ss_in = 1'b1;
    tick(2);
    for (int i = 0; i < 8; i++) begin
      bus.mosi_in = 1'b1;
      bus.miso_in = 1'b1;
      bus.sclk_in = 1'b0;
      tick(2);
      bus.sclk_in = 1'b1;
      tick(2);
    end
    chk("pre_reset_pass", {bus.ss_out, bus.mosi_out, bus.miso_out}, 3'b111);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midreset_outputs", {bus.ss_out, bus.sclk_out, bus.mosi_out, bus.miso_out, comm_active}, 0);
    chk("midreset_count", frame_count, 0);
    for (int i = 8; i < 20; i++) begin
      bus.sclk_in = 1'b0;
      tick(2);
      bus.sclk_in = 1'b1;
      tick(2);
    end
    bus.sclk_in = 1'b0;
    tick(2);
    bus.ss_in = 1'b0;
    tick(1);
    chk("cut_frame_ignored", {frame_valid, frame_error, comm_active}, 0);
    tick(3);
    run_frame(32'hC4D00, 32'h000A3, 20);
    chk("after_reset_valid", {fv, fe}, 2'b10);
    chk("after_reset_count", frame_count, 1);
    mode = 2'd3;
    run_frame(32'hD2000, 32'h000B5, 20);
    chk("block_outputs", {act, mo, so}, 0);
    chk("block_valid", {fv, fe}, 2'b10);
    chk("block_count", frame_count, 2);
    chk("block_frame_miso", frame_miso, 32'h000B5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
